// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: controller states, the NOP instruction word
// and the wrapping PC+4 helper.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: req/ack handshake to a variable-latency
// memory feeding the IF/ID register, absorbing decode stalls and branch flushes.
module imem_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PCF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchStall
);

    fetch_state_e state_q;
    logic [31:0]  req_addr_q;
    logic [31:0]  buf_instr_q;
    logic [31:0]  buf_pc4_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc4_q;
    logic         valid_q;
    logic         req_d;
    logic [31:0]  addr_d;
    logic         stall_d;

    // State, IF/ID register and skid buffer update
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= FETCH;
            instr_q     <= NOP;
            pc4_q       <= 32'd0;
            valid_q     <= 1'b0;
            req_addr_q  <= 32'd0;
            buf_instr_q <= 32'd0;
            buf_pc4_q   <= 32'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    req_addr_q <= PCF;
                    if (IMemAck) begin
                        if (FlushD) begin
                            instr_q <= NOP;
                            valid_q <= 1'b0;
                        end else if (StallD) begin
                            buf_instr_q <= IMemRData;
                            buf_pc4_q   <= pc_plus4(PCF);
                            state_q     <= HOLD;
                        end else begin
                            instr_q <= IMemRData;
                            pc4_q   <= pc_plus4(PCF);
                            valid_q <= 1'b1;
                        end
                    end else if (FlushD) begin
                        // The in-flight request belongs to the old PC; finish it from ReqAddr.
                        instr_q <= NOP;
                        valid_q <= 1'b0;
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (IMemAck) begin
                        state_q <= FETCH;
                    end
                end
                HOLD: begin
                    if (FlushD) begin
                        instr_q <= NOP;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end else if (!StallD) begin
                        instr_q <= buf_instr_q;
                        pc4_q   <= buf_pc4_q;
                        valid_q <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // Request/address/stall are combinational so a zero-wait ack completes in one cycle
    always_comb begin
        req_d   = 1'b0;
        addr_d  = PCF;
        stall_d = 1'b0;
        case (state_q)
            FETCH: begin
                req_d   = 1'b1;
                addr_d  = PCF;
                stall_d = ~IMemAck | (StallD & ~FlushD);
            end
            DROP: begin
                req_d   = 1'b1;
                addr_d  = req_addr_q;
                stall_d = 1'b1;
            end
            HOLD: begin
                req_d   = 1'b0;
                addr_d  = req_addr_q;
                stall_d = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                addr_d  = PCF;
                stall_d = 1'b0;
            end
        endcase
    end

    assign IMemReq    = req_d & ~RST;
    assign IMemAddr   = addr_d;
    assign FetchStall = stall_d;
    assign InstrD     = instr_q;
    assign PCPlus4D   = pc4_q;
    assign ValidD     = valid_q;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch-stage instruction-memory controller that consumes the fetch-stage program counter `PCF` and delivers instructions into the IF/ID pipeline register. It runs a req/ack handshake to a variable-latency instruction memory and returns `FetchStall`, which the hazard unit ORs into `StallF` so `PCF` holds while a fetch is outstanding. It also absorbs decode stalls and branch flushes (`FlushD`) without breaking the memory handshake.

## Interface
Parameters:
- `NOP`, 32'h0000_0000 — instruction word loaded into `InstrD` on reset/flush.

Ports:
- `CLK` in 1 — clock; all state updates on rising edge.
- `RST` in 1 — reset; synchronous, active-high.
- `PCF` in 32 — fetch address; held stable by the PC register while `FetchStall`=1.
- `StallD` in 1 — decode stall; IF/ID register must hold.
- `FlushD` in 1 — branch/jump redirect; current fetch result is discarded.
- `IMemReq` out 1 — memory request.
- `IMemAddr` out 32 — memory word address.
- `IMemAck` in 1 — memory response valid; may be asserted in the same cycle as `IMemReq` (zero-wait).
- `IMemRData` in 32 — instruction word; valid when `IMemAck`=1.
- `InstrD` out 32 — IF/ID instruction register.
- `PCPlus4D` out 32 — IF/ID PC+4 register.
- `ValidD` out 1 — `InstrD` holds a real fetched instruction.
- `FetchStall` out 1 — request to hold the PC (to the hazard unit).

## Operation
- States: FETCH, DROP, HOLD. Reset state: FETCH.
- Registers: `ReqAddr` (32), `BufInstr` (32), `BufPC4` (32).
- **FETCH**
  - Drives `IMemReq`=1, `IMemAddr`=`PCF`; `ReqAddr`<=`PCF` every cycle.
  - On `IMemAck` with `FlushD`: `InstrD`<=`NOP`, `ValidD`<=0; stay in FETCH.
  - On `IMemAck`, `StallD`=1, no flush: `BufInstr`<=`IMemRData`, `BufPC4`<=`PCF`+4; go to HOLD.
  - On `IMemAck`, no stall, no flush: `InstrD`<=`IMemRData`, `PCPlus4D`<=`PCF`+4, `ValidD`<=1.
  - No ack with `FlushD`: go to DROP. The outstanding request belongs to a stale PC.
  - No ack with `StallD`: hold.
- **DROP**
  - Drives `IMemReq`=1, `IMemAddr`=`ReqAddr`. The address must stay stable until ack.
  - On `IMemAck`: discard data; go to FETCH.
  - `InstrD`<=`NOP`, `ValidD`<=0 on entry.
- **HOLD**
  - `IMemReq`=0.
  - When `StallD`=0: `InstrD`<=`BufInstr`, `PCPlus4D`<=`BufPC4`, `ValidD`<=1; go to FETCH.
  - `FlushD` in HOLD, which takes priority over `StallD`: drop the buffer, `InstrD`<=`NOP`, `ValidD`<=0; go to FETCH.
- `FetchStall` = (FETCH & ~`IMemAck`) | DROP | HOLD | (FETCH & `IMemAck` & `StallD` & ~`FlushD`).
- Handshake rule: once `IMemReq` rises, `IMemReq` and `IMemAddr` stay constant until the cycle `IMemAck`=1 inclusive.
- Width rule: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 = 0.
- Priority, highest first: `RST` > `FlushD` > `StallD`.

## Timing
- Reset values (cycle after `RST` sampled high):
  - State = FETCH.
  - `InstrD`=`NOP`, `PCPlus4D`=0, `ValidD`=0.
  - `ReqAddr`=0, `BufInstr`=0, `BufPC4`=0.
  - `IMemReq` is forced to 0 while `RST`=1.
- Reset mid-operation: any outstanding request is abandoned. The memory must tolerate `IMemReq` dropping on reset.
- Latency: ack in cycle N → `InstrD` valid in cycle N+1. With zero-wait memory, throughput is 1 instruction/cycle and `FetchStall` stays 0.
- A wait of k cycles before ack gives `FetchStall`=1 for exactly k cycles.
- Flush with no ack pending costs 0 extra cycles. Flush with a request pending costs (remaining ack latency + 1) cycles.
- Ack coinciding with `FlushD` never leaves FETCH.

## Structure
- Shared package `mips_pkg`: state enum (FETCH/DROP/HOLD) and `NOP` constant.
- Single flat module; no sub-module warranted.

## Test plan
- **Zero-wait stream:** `IMemAck` tied to `IMemReq`, `PCF` 0,4,8 → `InstrD` tracks the data one cycle later, `PCPlus4D`=4,8,12, `FetchStall` always 0.
- **3-cycle memory latency:** `PCF`=0x40 → `FetchStall`=1 for 3 cycles with `IMemAddr` fixed at 0x40; then `InstrD`=data, `PCPlus4D`=0x44, `ValidD`=1.
- **Flush while pending:**
  - Stimulus: `PCF`=0x40, wait 1 cycle, pulse `FlushD` as `PCF` redirects to 0x100.
  - Required: `IMemAddr` stays 0x40 until ack and that data is discarded, with `ValidD`=0.
  - Then a fresh request issues to 0x100.
- **Decode stall on ack:** `StallD`=1 for 2 cycles when ack=0xDEADBEEF arrives → `InstrD` unchanged, `IMemReq`=0 in HOLD; on `StallD`=0, `InstrD`=0xDEADBEEF next cycle.
- **Flush + stall together in HOLD** → `InstrD`=`NOP`, `ValidD`=0, returns to FETCH.
- **Reset mid-DROP:** `RST` high one cycle → `IMemReq`=0 during reset; next cycle state FETCH and all registers at reset values.
